// File: rtl/button_pkg.sv
// Shared types and default timing constants for the pushbutton conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_t;

  // Short values keep simulation fast; SYN_* are 10 ms / 0.5 s / 0.1 s at 50 MHz.
  localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
  localparam int unsigned SIM_HOLD_CYCLES     = 8;
  localparam int unsigned SIM_REPEAT_CYCLES   = 3;

  localparam int unsigned SYN_DEBOUNCE_CYCLES = 500_000;
  localparam int unsigned SYN_HOLD_CYCLES     = 25_000_000;
  localparam int unsigned SYN_REPEAT_CYCLES   = 5_000_000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with a selectable reset value.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces an active-low pushbutton into a clean level, press/release pulses
// and an optional hold-to-repeat pulse train; Event is the downstream load strobe.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = SIM_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = SIM_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn_n,
  output logic Level,
  output logic Press,
  output logic Release,
  output logic Repeat,
  output logic Event
);

  localparam int unsigned CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  btn_state_t    state, state_next;
  logic [CW-1:0] db_cnt, db_cnt_next;
  logic [CW-1:0] hold_cnt, hold_cnt_next;
  logic [CW-1:0] hold_target;
  logic          first, first_next;
  logic          level_next, press_next, release_next, repeat_next;
  logic          btn_sync, btn_s;

  // Idle-high reset value so a freshly reset synchronizer reads "released".
  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk (Clk),
    .rst (Reset),
    .d   (Btn_n),
    .q   (btn_sync)
  );

  assign btn_s       = ~btn_sync;
  assign hold_target = first ? HOLD_LAST : REPEAT_LAST;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= RELEASED;
      db_cnt   <= '0;
      hold_cnt <= '0;
      first    <= 1'b0;
      Level    <= 1'b0;
      Press    <= 1'b0;
      Release  <= 1'b0;
      Repeat   <= 1'b0;
      Event    <= 1'b0;
    end else begin
      state    <= state_next;
      db_cnt   <= db_cnt_next;
      hold_cnt <= hold_cnt_next;
      first    <= first_next;
      Level    <= level_next;
      Press    <= press_next;
      Release  <= release_next;
      Repeat   <= repeat_next;
      Event    <= press_next | repeat_next;
    end
  end

  always_comb begin
    state_next    = state;
    db_cnt_next   = db_cnt;
    hold_cnt_next = hold_cnt;
    first_next    = first;
    press_next    = 1'b0;
    release_next  = 1'b0;
    repeat_next   = 1'b0;

    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_next  = DB_PRESS;
          db_cnt_next = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_next = RELEASED;
        end else if (db_cnt == DB_LAST) begin
          state_next    = PRESSED;
          db_cnt_next   = '0;
          press_next    = 1'b1;
          hold_cnt_next = '0;
          first_next    = 1'b1;
        end else begin
          db_cnt_next = db_cnt + CW'(1);
        end
      end
      PRESSED: begin
        // hold_cnt stays frozen across DB_RELEASE so a bounce does not restart the repeat timer.
        if (!btn_s) begin
          state_next  = DB_RELEASE;
          db_cnt_next = '0;
        end else if (REPEAT_EN) begin
          if (hold_cnt == hold_target) begin
            repeat_next   = 1'b1;
            hold_cnt_next = '0;
            first_next    = 1'b0;
          end else begin
            hold_cnt_next = hold_cnt + CW'(1);
          end
        end
      end
      DB_RELEASE: begin
        if (btn_s) begin
          state_next = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_next   = RELEASED;
          db_cnt_next  = '0;
          release_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt + CW'(1);
        end
      end
      default: state_next = RELEASED;
    endcase

    level_next = (state_next == PRESSED) || (state_next == DB_RELEASE);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a run-length reference model.
module tb_button_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned H = 8;
  localparam int unsigned R = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Btn_n = 1'b1;
  logic Level, Press, Release, Repeat, Event;
  logic nr_level, nr_press, nr_release, nr_repeat, nr_event;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R),
    .REPEAT_EN       (1'b1)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Btn_n   (Btn_n),
    .Level   (Level),
    .Press   (Press),
    .Release (Release),
    .Repeat  (Repeat),
    .Event   (Event)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R),
    .REPEAT_EN       (1'b0)
  ) dut_norep (
    .Clk     (Clk),
    .Reset   (Reset),
    .Btn_n   (Btn_n),
    .Level   (nr_level),
    .Press   (nr_press),
    .Release (nr_release),
    .Repeat  (nr_repeat),
    .Event   (nr_event)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the accepted level flips after D+1 consecutive opposing
  // samples (seen two edges late); repeats fall at held-edge counts H, H+R, H+2R...
  bit   pipe[$] = '{1'b0, 1'b0};
  int   run = 0;
  int   held = 0;
  bit   m_level = 1'b0;
  logic exp_level = 1'b0, exp_press = 1'b0, exp_release = 1'b0, exp_repeat = 1'b0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pipe = '{1'b0, 1'b0};
      run = 0;
      held = 0;
      m_level = 1'b0;
      exp_level = 1'b0;
      exp_press = 1'b0;
      exp_release = 1'b0;
      exp_repeat = 1'b0;
    end else begin
      bit s;
      pipe.push_back(!Btn_n);
      s = pipe.pop_front();
      exp_press = 1'b0;
      exp_release = 1'b0;
      exp_repeat = 1'b0;
      if (s != m_level) begin
        run++;
        if (run == int'(D) + 1) begin
          m_level = s;
          run = 0;
          if (s) begin
            exp_press = 1'b1;
            held = 0;
          end else begin
            exp_release = 1'b1;
          end
        end
      end else begin
        if (run == 0 && m_level) begin
          held++;
          if (held >= int'(H) && ((held - int'(H)) % int'(R)) == 0) exp_repeat = 1'b1;
        end
        run = 0;
      end
      exp_level = m_level;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("level", Level, exp_level);
      check("press", Press, exp_press);
      check("release", Release, exp_release);
      check("repeat", Repeat, exp_repeat);
      check("event", Event, exp_press | exp_repeat);
      check("norep_level", nr_level, exp_level);
      check("norep_press", nr_press, exp_press);
      check("norep_release", nr_release, exp_release);
      check("norep_repeat", nr_repeat, 1'b0);
      check("norep_event", nr_event, exp_press);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    @(negedge Clk);
    Btn_n = v;
    repeat (n) @(posedge Clk);
  endtask

  initial begin
    logic saw;
    #1 Reset = 1'b1;
    #1;
    check("reset_level", Level, 1'b0);
    check("reset_event", Event, 1'b0);
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    chk_en = 1'b1;
    step(10);
    check("idle_level", Level, 1'b0);

    // Clean press and hold-repeat timing.
    @(negedge Clk) Btn_n = 1'b0;
    step(6);
    check("press_early", Press, 1'b0);
    step(1);
    check("press_edge6", Press, 1'b1);
    check("level_edge6", Level, 1'b1);
    check("event_edge6", Event, 1'b1);
    step(1);
    check("press_one_cycle", Press, 1'b0);
    check("level_held", Level, 1'b1);
    step(7);
    check("repeat_edge14", Repeat, 1'b1);
    check("event_edge14", Event, 1'b1);
    step(2);
    check("repeat_edge16", Repeat, 1'b0);
    step(1);
    check("repeat_edge17", Repeat, 1'b1);

    // Release with a one-sample glitch.
    @(negedge Clk) Btn_n = 1'b1;
    @(negedge Clk);
    @(negedge Clk) Btn_n = 1'b0;
    @(negedge Clk) Btn_n = 1'b1;
    step(6);
    check("release_early", Release, 1'b0);
    check("level_before_release", Level, 1'b1);
    step(1);
    check("release_edge6", Release, 1'b1);
    check("level_falls_with_release", Level, 1'b0);
    step(12);

    // Bounce rejection.
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 3);
    @(negedge Clk) Btn_n = 1'b1;
    saw = 1'b0;
    repeat (14) begin
      @(posedge Clk);
      #1;
      saw = saw | Level | Press | Event;
    end
    check("bounce_quiet", saw, 1'b0);

    // Async reset while held, then fresh press after deassert.
    drive(1'b0, 8);
    #3 Reset = 1'b1;
    #1;
    check("async_level", Level, 1'b0);
    check("async_press", Press, 1'b0);
    check("async_release", Release, 1'b0);
    check("async_event", Event, 1'b0);
    #2 Reset = 1'b0;
    step(6);
    check("post_reset_press_early", Press, 1'b0);
    step(1);
    check("post_reset_press", Press, 1'b1);
    drive(1'b1, 12);

    // Repeat timer freezes across an aborted release.
    drive(1'b0, 7);
    #1;
    check("freeze_press", Press, 1'b1);
    repeat (3) @(posedge Clk);
    drive(1'b1, 2);
    @(negedge Clk) Btn_n = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(posedge Clk);
      #1;
      saw = saw | Repeat;
    end
    check("freeze_no_repeat", saw, 1'b0);
    step(1);
    check("freeze_repeat", Repeat, 1'b1);
    drive(1'b1, 12);

    // Random bounce, hold and reset traffic.
    for (int seg = 0; seg < 300; seg++) begin
      int unsigned kind;
      int unsigned len;
      kind = $urandom_range(0, 19);
      if (kind == 0) begin
        @(posedge Clk);
        #3 Reset = 1'b1;
        @(posedge Clk);
        #3 Reset = 1'b0;
      end else begin
        len = (kind < 8) ? $urandom_range(1, 5) : $urandom_range(6, 40);
        drive(logic'($urandom_range(0, 1)), int'(len));
      end
    end
    drive(1'b1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the accumulator's run/load control.
- Converts one raw, bouncing, active-low pushbutton into clean synchronous signals:
  - a debounced level;
  - single-cycle press and release pulses;
  - an optional hold-to-repeat pulse train.
- Event (press or repeat) drives the register load enable, so holding Run accumulates repeatedly.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a change; must be >=1 (synthesis value 500000 = 10 ms at 50 MHz).
- HOLD_CYCLES, 8, cycles in PRESSED before the first Repeat; must be >=1.
- REPEAT_CYCLES, 3, cycles between subsequent Repeat pulses; must be >=1.
- REPEAT_EN, 1, 1 enables Repeat; 0 holds Repeat at 0.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Btn_n  input  1  raw pushbutton, active-low, asynchronous to Clk.
- Level  output  1  debounced pressed state, active-high.
- Press  output  1  one-cycle pulse on accepted press.
- Release  output  1  one-cycle pulse on accepted release.
- Repeat  output  1  one-cycle pulse per auto-repeat tick.
- Event  output  1  Press OR Repeat (registered); load strobe for downstream.

Behaviour:
- Reset (async, active-high):
  - synchronizer FFs go to 1 (released);
  - state goes to RELEASED;
  - all counters go to 0;
  - Level, Press, Release, Repeat and Event go to 0.
- Reset asserted mid-press aborts with no Release pulse. A button still held when Reset deasserts is debounced fresh and yields a Press.
- Synchronizer: 2 FFs. btn_s = NOT sync2, so btn_s is valid 2 edges after Btn_n is first sampled.
- Outputs are registered; no combinational path from Btn_n.
- States:
  - RELEASED: Level=0.
    - btn_s=1 -> DB_PRESS, db_cnt=0.
  - DB_PRESS: Level=0.
    - btn_s=0 -> RELEASED (bounce rejected, no pulse).
    - else if db_cnt==DEBOUNCE_CYCLES-1 -> PRESSED; Press=1 and Event=1 for the next cycle; hold_cnt=0, first=1.
    - else db_cnt++.
  - PRESSED: Level=1.
    - btn_s=0 -> DB_RELEASE, db_cnt=0; hold_cnt is frozen.
    - else hold_cnt++. When REPEAT_EN and hold_cnt reaches its target (HOLD_CYCLES-1 if first, else REPEAT_CYCLES-1): Repeat=1 and Event=1 next cycle; hold_cnt=0, first=0.
  - DB_RELEASE: Level=1.
    - btn_s=1 -> PRESSED; hold_cnt resumes from its frozen value, no new Press.
    - else if db_cnt==DEBOUNCE_CYCLES-1 -> RELEASED; Release=1 for one cycle; Level=0 in the same cycle as Release.
    - else db_cnt++.
    - No Repeat is issued while in this state.
- Latency, counting edge 0 as the edge that first samples Btn_n low:
  - Press and Level rise after edge DEBOUNCE_CYCLES+2.
  - First Repeat comes HOLD_CYCLES edges after Press rises; later Repeats every REPEAT_CYCLES edges.
  - Release follows the same 2+DEBOUNCE_CYCLES rule from the first sampled high.
- Press, Release and Repeat are mutually exclusive in any cycle.
- Press and Repeat can never coincide (Repeat needs at least 1 cycle in PRESSED), so Event is always one pulse per cycle.
- Counter widths: $clog2(max parameter + 1). Counters never wrap: each is cleared at its target or on a state change.

Decomposition:
- Package button_pkg:
  - typedef enum logic [1:0] btn_state_t {RELEASED, DB_PRESS, PRESSED, DB_RELEASE};
  - default-parameter constants for simulation and synthesis (10 ms debounce, 0.5 s hold, 0.1 s repeat at 50 MHz).
- Sub-module sync_2ff:
  - 1-bit two-flop synchronizer.
  - Reset value is a parameter, set to 1 here.
  - Reused later for switch inputs.

Test Plan (defaults D=4, H=8, R=3):
- Clean press: drive Btn_n low before edge 0 and hold it low -> Press, Event and Level rise after edge 6. Press and Event stay high one cycle; Level stays high. No Release.
- Bounce rejection: Btn_n low 3 cycles, high 1, low 3, high -> Level, Press and Event stay 0 throughout; state returns to RELEASED.
- Release with glitch: from PRESSED, Btn_n high 2 cycles, low 1, then high steady -> no Release at the glitch. Release rises exactly 6 edges after the final high is first sampled; Level falls in the same cycle.
- Hold-repeat: press at edge 0 and hold -> Press after edge 6; Repeat and Event after edges 14, 17, 20, 23. With REPEAT_EN=0 -> no Repeat.
- Async reset mid-hold: assert Reset between edges while in PRESSED -> all outputs 0 immediately, with no clock edge needed. Deassert with the button still held -> Press occurs 6 edges after the first post-reset sample.
- Repeat freeze: in PRESSED with hold_cnt=5, Btn_n high 2 cycles, then low -> no Repeat during DB_RELEASE. After return, the first Repeat comes on the 3rd PRESSED edge (hold_cnt resumes at 5 and reaches 7).
